int_sync_crossing_sink: RTL



---
 rtl/int_sync_pkg.sv | 31 +++
 rtl/async_reset_sync_shift_reg.sv | 38 +++
 rtl/int_sync_crossing_sink.sv | 96 +++++++++
 3 files changed

// File: rtl/int_sync_pkg.sv
// ---------------------------------------------------------------------------
// int_sync_pkg
// Shared constants and helpers for the interrupt sync crossing sink.
// Holds the legal ranges for the synchronizer depth and filter length, the
// filter counter width helper, and the range predicates the top module uses
// to reject bad parameterisations when the design is elaborated.
// No ports (package).
// ---------------------------------------------------------------------------
package int_sync_pkg;

   localparam int MIN_SYNC_STAGES   = 2;
   localparam int MAX_SYNC_STAGES   = 8;
   localparam int MAX_FILTER_CYCLES = 255;

   // Counter must hold 0..FILTER_CYCLES; never narrower than one bit so the
   // declaration stays legal even when the filter is bypassed.
   function automatic int filterCntWidth(input int filterCycles);
      int w;
      w = $clog2(filterCycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit syncStagesLegal(input int syncStages);
      return (syncStages >= MIN_SYNC_STAGES) && (syncStages <= MAX_SYNC_STAGES);
   endfunction

   function automatic bit filterCyclesLegal(input int filterCycles);
      return (filterCycles >= 0) && (filterCycles <= MAX_FILTER_CYCLES);
   endfunction

endpackage

// File: rtl/async_reset_sync_shift_reg.sv
// ---------------------------------------------------------------------------
// async_reset_sync_shift_reg
// Single-bit multi-flop synchronizer with asynchronous active-high reset to 0.
// This is the only place synchronizer flops live, so CDC constraints
// (false path into stage 0, placement of the chain) attach to this module.
// Ports:
//   clock  - local-domain clock
//   reset  - asynchronous active-high reset, clears every stage to 0
//   i_d    - asynchronous input bit, feeds stage 0 only
//   o_q    - output of the last stage
// ---------------------------------------------------------------------------
module async_reset_sync_shift_reg
   import int_sync_pkg::*;
#(
   parameter int SYNC_STAGES = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_syncChain;

   // Plain shift chain: stage 0 samples the foreign-domain bit, each later
   // stage only copies its predecessor so metastability has full cycles to
   // resolve. Nothing combinational may ever be inserted between stages.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_syncChain <= '0;
      end else begin
         r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_syncChain[SYNC_STAGES-1];

endmodule

// File: rtl/int_sync_crossing_sink.sv
// ---------------------------------------------------------------------------
// int_sync_crossing_sink
// Receiving end of the interrupt sync crossing. Each bit of the register-
// driven interrupt vector from the source domain is resynchronised into the
// local clock domain, optionally deglitched (FILTER_CYCLES > 0), and a
// one-cycle rising-edge pulse is produced for edge-triggered consumers.
// Bits are handled fully independently; there is no multi-bit coherence.
// Ports:
//   clock         - local-domain clock
//   reset         - asynchronous active-high reset, clears all state to 0
//   auto_in_sync  - [WIDTH] interrupt levels from the source, asynchronous
//   auto_out      - [WIDTH] synchronised (and filtered) interrupt levels
//   auto_out_rise - [WIDTH] high for exactly the first cycle auto_out[i] is 1
// ---------------------------------------------------------------------------
module int_sync_crossing_sink
   import int_sync_pkg::*;
#(
   parameter int WIDTH         = 2,
   parameter int SYNC_STAGES   = 3,
   parameter int FILTER_CYCLES = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] auto_in_sync,
   output logic [WIDTH-1:0] auto_out,
   output logic [WIDTH-1:0] auto_out_rise
);

   // Refuse to elaborate outside the supported parameter ranges.
   if (!syncStagesLegal(SYNC_STAGES)) begin : g_badSyncStages
      $fatal(1, "int_sync_crossing_sink: SYNC_STAGES out of range 2..8");
   end
   if (!filterCyclesLegal(FILTER_CYCLES)) begin : g_badFilterCycles
      $fatal(1, "int_sync_crossing_sink: FILTER_CYCLES out of range 0..255");
   end

   logic [WIDTH-1:0] w_syncOut;
   logic [WIDTH-1:0] w_filtOut;
   logic [WIDTH-1:0] r_riseHist;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit

      async_reset_sync_shift_reg #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clock (clock),
         .reset (reset),
         .i_d   (auto_in_sync[i]),
         .o_q   (w_syncOut[i])
      );

      if (FILTER_CYCLES == 0) begin : g_bypass
         assign w_filtOut[i] = w_syncOut[i];
      end else begin : g_filter
         localparam int               CNT_W    = filterCntWidth(FILTER_CYCLES);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

         logic             r_filtBit;
         logic [CNT_W-1:0] r_filtCnt;

         // Deglitch: the output only follows the synchronised bit after it
         // has disagreed with the output on FILTER_CYCLES consecutive edges.
         // Any edge where they agree again throws the partial count away, so
         // short pulses of either polarity never reach the output.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_filtBit <= 1'b0;
               r_filtCnt <= '0;
            end else if (w_syncOut[i] == r_filtBit) begin
               r_filtCnt <= '0;
            end else if (r_filtCnt == CNT_LAST) begin
               r_filtBit <= w_syncOut[i];
               r_filtCnt <= '0;
            end else begin
               r_filtCnt <= r_filtCnt + 1'b1;
            end
         end

         assign w_filtOut[i] = r_filtBit;
      end
   end

   // History of the delivered level; the rise pulse is formed from two
   // flop outputs only, so it cannot glitch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_riseHist <= '0;
      end else begin
         r_riseHist <= w_filtOut;
      end
   end

   assign auto_out      = w_filtOut;
   assign auto_out_rise = w_filtOut & ~r_riseHist;

endmodule
